muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values are even and at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request strobe qualifying opcode/funct.
REQ-005 SHALL have port opcode, input, 6, instruction opcode; only RTYPE_OP (0x00) is acted on.
REQ-006 SHALL have port funct, input, 6, one of MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
REQ-007 SHALL have port operandA, input, WIDTH, multiplicand, dividend, or MTHI/MTLO source.
REQ-008 SHALL have port operandB, input, WIDTH, multiplier or divisor.
REQ-009 SHALL have port busy, output, 1, high while an iterative operation is in flight.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when HI/LO take a MULT/DIV result.
REQ-011 SHALL have port div_by_zero, output, 1, registered; valid with done.
REQ-012 SHALL have port hi, output, WIDTH, HI register.
REQ-013 SHALL have port lo, output, WIDTH, LO register.
REQ-014 SHALL have port res, output, WIDTH, combinational: hi when funct=MFHI, lo when funct=MFLO, else 0.
REQ-015 SHALL have port zero, output, 1, combinational: high when res is all zeros.

Function
REQ-016 SHALL implement the states IDLE, MUL, DIV, and FIXUP.
REQ-017 In IDLE, start=1 with opcode=0 and funct in {MULT, MULTU} SHALL latch the operands, set the iteration counter to WIDTH, and go to MUL.
REQ-018 In IDLE, start=1 with opcode=0 and funct in {DIV, DIVU} SHALL latch the operands, set the iteration counter to WIDTH, and go to DIV.
REQ-019 For signed ops, the unit SHALL latch operand magnitudes and record the result signs: product sign = signA xor signB; quotient sign = signA xor signB; remainder sign = signA.
REQ-020 MUL SHALL perform one shift-add iteration per cycle; DIV SHALL perform one restoring shift-subtract iteration per cycle; both SHALL decrement the counter each cycle.
REQ-021 When the counter reaches 0, MUL/DIV SHALL go to FIXUP; FIXUP SHALL apply two's-complement sign correction, write hi/lo, and return to IDLE.
REQ-022 busy SHALL be 1 in MUL, DIV, and FIXUP, and 0 in IDLE.
REQ-023 done SHALL be 1 for exactly the one cycle after FIXUP.
REQ-024 Latency SHALL be fixed at WIDTH+1 rising edges, from the accepting edge to the edge on which hi/lo update and done rises.
REQ-025 Multiply results SHALL be: hi = upper WIDTH bits and lo = lower WIDTH bits of the 2*WIDTH-bit product.
REQ-026 Divide results SHALL be: lo = quotient truncated toward zero; hi = remainder.
REQ-027 On a zero divisor, DIV/DIVU SHALL still take WIDTH+1 edges and then give hi = operandA, lo = all ones, and div_by_zero = 1.
REQ-028 div_by_zero SHALL be cleared on any accepted start.
REQ-029 Signed DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0, with no flag.
REQ-030 In IDLE, start with MTHI or MTLO SHALL write operandA into hi or lo on that edge; busy stays 0 and done stays 0.
REQ-031 Any start while busy=1 SHALL be ignored, with no effect on state, operands, or hi/lo.
REQ-032 Start with opcode≠0, or with a funct outside REQ-006, SHALL be ignored.
REQ-033 hi and lo SHALL hold their values between writes; MFHI/MFLO reads SHALL be legal in any state and return the current registers.
REQ-034 Intermediate iteration state SHALL NOT be visible on hi, lo, or res before the done edge.

Reset
REQ-035 reset=1 at a rising edge SHALL force IDLE and clear hi, lo, counter, busy, done, and div_by_zero to 0.
REQ-036 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL NOT write hi/lo afterwards.
REQ-037 After reset, the first start SHALL be accepted on the first edge on which reset=0.

Verification (WIDTH=32)
REQ-038 The bench SHALL check: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done after 33 edges, hi=0xFFFFFFFE, lo=0x00000001, busy high for 33 cycles.
REQ-039 The bench SHALL check: MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MFLO gives res=0xFFFFFFEB and zero=0.
REQ-040 The bench SHALL check: DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 The bench SHALL check: DIVU 7 / 0 -> done after 33 edges, div_by_zero=1, hi=7, lo=0xFFFFFFFF; the next accepted start clears div_by_zero.
REQ-042 The bench SHALL check: MULTU 5 x 6 with a second start (MTLO 0x1234) issued mid-operation -> second start ignored, lo=30, hi=0.
REQ-043 The bench SHALL check: MTHI 0xDEADBEEF, then MULT started and reset asserted 10 cycles in -> hi=lo=0, busy=0, done never asserts, MFHI gives res=0 and zero=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for R-type MULT/DIV ops.
//
// MULT/MULTU multiply with one shift-add step per cycle. DIV/DIVU divide with
// one restoring shift-subtract step per cycle. Each operation takes exactly
// WIDTH+1 clock edges from the accepting edge to the edge that writes hi/lo.
// MTHI/MTLO write hi/lo directly while the unit is idle. MFHI/MFLO are
// combinational reads on res.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active high
//   start        request strobe that qualifies opcode/funct
//   opcode       instruction opcode; only 0x00 (R-type) is acted on
//   funct        MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU
//   operandA     multiplicand, dividend, or MTHI/MTLO source
//   operandB     multiplier or divisor
//   busy         high while an iterative operation is in flight
//   done         one-cycle pulse when hi/lo take a MULT/DIV result
//   div_by_zero  registered; valid with done
//   hi, lo       HI and LO registers
//   res          hi for MFHI, lo for MFLO, otherwise 0
//   zero         high when res is all zeros
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; MTHI/MTLO are serviced here
// MUL    | one shift-add step per cycle, counter runs WIDTH -> 0
// DIV    | one restoring shift-subtract step per cycle, counter WIDTH -> 0
// FIXUP  | sign correction, hi/lo written, done raised on the way to IDLE
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MUL   = 2'd1;
    localparam logic [1:0] DIV   = 2'd2;
    localparam logic [1:0] FIXUP = 2'd3;

    localparam logic [5:0] RTYPE_OP = 6'h00;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MTHI   = 6'h11;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MTLO   = 6'h13;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // mcand holds the multiplicand magnitude for MUL and the divisor
    // magnitude for DIV. p_hi/p_lo are the product accumulator for MUL and
    // {remainder, quotient/dividend} for DIV.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] dvz_a;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;
    logic             is_div;

    logic             accept;
    logic             is_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept    = start && (opcode == RTYPE_OP) && (state == IDLE);
    assign is_signed = (funct == F_MULT) || (funct == F_DIV);
    assign abs_a     = (is_signed && operandA[WIDTH-1]) ? -operandA : operandA;
    assign abs_b     = (is_signed && operandB[WIDTH-1]) ? -operandB : operandB;

    // Carry out of the add lands in the top bit and is shifted down into p_hi.
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign prod_fix  = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};

    assign busy = (state != IDLE);

    always_comb begin
        res = '0;
        if (funct == F_MFHI)      res = hi;
        else if (funct == F_MFLO) res = lo;
    end

    assign zero = (res == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            mcand       <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            dvz_a       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            is_div      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (funct)
                            F_MULT, F_MULTU: begin
                                mcand       <= abs_a;
                                p_hi        <= '0;
                                p_lo        <= abs_b;
                                neg_q       <= is_signed && (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
                                neg_r       <= 1'b0;
                                is_div      <= 1'b0;
                                cnt         <= CW'(WIDTH);
                                div_by_zero <= 1'b0;
                                state       <= MUL;
                            end
                            F_DIV, F_DIVU: begin
                                mcand       <= abs_b;
                                p_hi        <= '0;
                                p_lo        <= abs_a;
                                dvz_a       <= operandA;
                                b_zero      <= (operandB == '0);
                                neg_q       <= is_signed && (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
                                neg_r       <= is_signed && operandA[WIDTH-1];
                                is_div      <= 1'b1;
                                cnt         <= CW'(WIDTH);
                                div_by_zero <= 1'b0;
                                state       <= DIV;
                            end
                            F_MTHI: begin
                                hi          <= operandA;
                                div_by_zero <= 1'b0;
                            end
                            F_MTLO: begin
                                lo          <= operandA;
                                div_by_zero <= 1'b0;
                            end
                            F_MFHI, F_MFLO: begin
                                div_by_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
                    cnt          <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIXUP;
                end
                DIV: begin
                    if (div_ge) begin
                        p_hi <= WIDTH'(div_shift - {1'b0, mcand});
                        p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        p_hi <= div_shift[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    if (is_div) begin
                        if (b_zero) begin
                            hi          <= dvz_a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            lo <= neg_q ? -p_lo : p_lo;
                            hi <= neg_r ? -p_hi : p_hi;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [5:0]  opcode, funct;
    logic [31:0] operandA, operandB;
    logic        busy, done, div_by_zero, zero;
    logic [31:0] hi, lo, res;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
        .operandA(operandA), .operandB(operandB), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .res(res), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] mh, output logic [31:0] ml, output logic md);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        md = 1'b0;
        mh = '0;
        ml = '0;
        case (f)
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                mh = p[63:32]; ml = p[31:0];
            end
            F_MULT: begin
                p = 64'(sa * sb);
                mh = p[63:32]; ml = p[31:0];
            end
            F_DIVU: begin
                if (b == 0) begin mh = a; ml = '1; md = 1'b1; end
                else begin ml = a / b; mh = a % b; end
            end
            F_DIV: begin
                if (b == 0) begin mh = a; ml = '1; md = 1'b1; end
                else begin
                    q = sa / sb; r = sa % sb;
                    ml = q[31:0]; mh = r[31:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; opcode = 6'h00; funct = f; operandA = a; operandB = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after the accepting edge; edges counts from that edge.
    task automatic wait_done(input logic [31:0] old_hi, input logic [31:0] old_lo,
                             output int edges, output int bcnt);
        edges = 0;
        bcnt = busy ? 1 : 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 16) begin
                chk("mid_hi_hidden", hi, old_hi);
                chk("mid_lo_hidden", lo, old_lo);
            end
            if (done) break;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_check(input string tag, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                             input logic ed);
        int edges, bcnt;
        logic [31:0] oh, ol;
        oh = hi; ol = lo;
        issue(f, a, b);
        chk({tag, "_dbz_clear"}, {31'b0, div_by_zero}, 32'd0);
        wait_done(oh, ol, edges, bcnt);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_latency"}, edges, 32'd33);
        chk({tag, "_busy_cycles"}, bcnt, 32'd33);
        chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        funct = F_MFHI;
        #1;
        chk({tag, "_mfhi"}, res, eh);
        funct = F_MFLO;
        #1;
        chk({tag, "_mflo"}, res, el);
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, (el == 32'd0)});
    endtask

    initial begin
        int edges, bcnt;
        logic [31:0] oh, ol, mh, ml;
        logic md, seen_done;
        logic [5:0] rf;
        logic [31:0] ra, rb;

        tbl[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1] = '{F_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[4] = '{F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[6] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[7] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

        reset = 1'b1; start = 1'b0; opcode = 6'h00; funct = 6'h00;
        operandA = '0; operandB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a, tbl[i].b,
                      tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_dbz);

        // A start issued mid-operation must be ignored.
        oh = hi; ol = lo;
        issue(F_MULTU, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct = F_MTLO; operandA = 32'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("midstart_lo_held", lo, ol);
        wait_done(oh, ol, edges, bcnt);
        chk("midstart_done", {31'b0, done}, 32'd1);
        chk("midstart_lo", lo, 32'd30);
        chk("midstart_hi", hi, 32'd0);

        // Ignored requests: non-R-type opcode and an unknown funct.
        @(negedge clk);
        start = 1'b1; opcode = 6'h01; funct = F_MTHI; operandA = 32'h99;
        @(posedge clk);
        #1;
        start = 1'b0; opcode = 6'h00;
        chk("bad_opcode_hi", hi, 32'd0);
        issue(6'h20, 32'h5, 32'h5);
        chk("bad_funct_busy", {31'b0, busy}, 32'd0);

        // MTHI, then a MULT aborted by reset.
        issue(F_MTHI, 32'hDEADBEEF, 32'd0);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_done", {31'b0, done}, 32'd0);
        issue(F_MULT, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", {31'b0, seen_done}, 32'd0);
        chk("abort_hi_after", hi, 32'd0);
        chk("abort_lo_after", lo, 32'd0);
        funct = F_MFHI;
        #1;
        chk("abort_mfhi_res", res, 32'd0);
        chk("abort_mfhi_zero", {31'b0, zero}, 32'd1);

        // Reset beats a coincident start; first edge after reset accepts.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; funct = F_MTHI; operandA = 32'h77;
        @(posedge clk);
        #1;
        chk("rst_prio_hi", hi, 32'd0);
        @(negedge clk);
        reset = 1'b0; funct = F_MTLO; operandA = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_after_rst_lo", lo, 32'h55);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rf = F_MULT;
                1: rf = F_MULTU;
                2: rf = F_DIV;
                default: rf = F_DIVU;
            endcase
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2, 3: rb = 32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            model(rf, ra, rb, mh, ml, md);
            run_check($sformatf("rnd%0d", i), rf, ra, rb, mh, ml, md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
